// File: rtl/activation_unit_n.sv
// Integrate-and-fire activation stage: NUM_CHANNELS independent neurons with
// reset-by-subtraction and saturating spike counters. Optional leak: define ACT_LEAK_EN.
module activation_unit_n #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int TIMER_WIDTH  = 5,
    parameter int LEAK_SHIFT   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                in_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  current_in,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  threshold,
    output logic                                out_valid,
    output logic [NUM_CHANNELS-1:0]             out_spike,
    output logic [NUM_CHANNELS*TIMER_WIDTH-1:0] accumulated_spikes,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]  membrane_out
);

    localparam logic signed [DATA_WIDTH-1:0] ZERO_V   = {DATA_WIDTH{1'b0}};
    localparam logic signed [DATA_WIDTH-1:0] MAX_V    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_V    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [TIMER_WIDTH-1:0]       CNT_ZERO = {TIMER_WIDTH{1'b0}};
    localparam logic [TIMER_WIDTH-1:0]       CNT_MAX  = {TIMER_WIDTH{1'b1}};

    if (NUM_CHANNELS < 1 || LEAK_SHIFT < 1 || LEAK_SHIFT >= DATA_WIDTH) begin : g_bad_param
        $error("activation_unit_n: illegal NUM_CHANNELS or LEAK_SHIFT");
    end

    // Add at one extra bit, then clamp to the representable signed range.
    function automatic logic signed [DATA_WIDTH-1:0] sat_add(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH:0] sum;
        sum = $signed({a[DATA_WIDTH-1], a}) + $signed({b[DATA_WIDTH-1], b});
        if (sum[DATA_WIDTH] == 1'b1 && sum[DATA_WIDTH-1] == 1'b0) begin
            sat_add = MIN_V;
        end else if (sum[DATA_WIDTH] == 1'b0 && sum[DATA_WIDTH-1] == 1'b1) begin
            sat_add = MAX_V;
        end else begin
            sat_add = sum[DATA_WIDTH-1:0];
        end
    endfunction

    logic [NUM_CHANNELS-1:0] fire_vec_s;
    logic                    out_valid_d, out_valid_q;
    logic [NUM_CHANNELS-1:0] out_spike_d, out_spike_q;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] cur_s, thr_s, base_s, sum_s;
        logic signed [DATA_WIDTH-1:0] mem_d, mem_q;
        logic [TIMER_WIDTH-1:0]       cnt_d, cnt_q;
        logic                         fire_s;

        assign cur_s = current_in[g*DATA_WIDTH +: DATA_WIDTH];
        assign thr_s = threshold[g*DATA_WIDTH +: DATA_WIDTH];
`ifdef ACT_LEAK_EN
        // Shrinking toward zero never overflows, for either sign.
        assign base_s = mem_q - (mem_q >>> LEAK_SHIFT);
`else
        assign base_s = mem_q;
`endif

        // Integrate, compare against threshold and compute next membrane/count.
        always_comb begin
            sum_s  = sat_add(base_s, cur_s);
            fire_s = (thr_s > ZERO_V) && (sum_s >= thr_s);
            mem_d  = mem_q;
            cnt_d  = cnt_q;
            if (clear) begin
                mem_d = ZERO_V;
                cnt_d = CNT_ZERO;
            end else if (in_valid) begin
                if (fire_s) begin
                    mem_d = sum_s - thr_s;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + TIMER_WIDTH'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    mem_d = sum_s;
                end
            end else begin
                mem_d = mem_q;
            end
        end

        // Per-channel membrane and spike-count state.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem_q <= ZERO_V;
                cnt_q <= CNT_ZERO;
            end else begin
                mem_q <= mem_d;
                cnt_q <= cnt_d;
            end
        end

        assign fire_vec_s[g]                                 = fire_s;
        assign membrane_out[g*DATA_WIDTH +: DATA_WIDTH]      = mem_q;
        assign accumulated_spikes[g*TIMER_WIDTH +: TIMER_WIDTH] = cnt_q;
    end

    // Output handshake: a cleared timestep produces neither valid nor spikes.
    always_comb begin
        out_valid_d = in_valid && !clear;
        if (out_valid_d) begin
            out_spike_d = fire_vec_s;
        end else begin
            out_spike_d = {NUM_CHANNELS{1'b0}};
        end
    end

    // Output valid/spike registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_spike_q <= {NUM_CHANNELS{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_spike_q <= out_spike_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_spike = out_spike_q;

endmodule

// File: tb/tb_activation_unit_n.sv
// Self-checking bench for activation_unit_n: vector table, hand sequences and
// randomized traffic against an integer reference model.
module tb_activation_unit_n;
    localparam int NC = 4;
    localparam int DW = 16;
    localparam int TW = 5;
    localparam int LS = 1;

    logic                 clk = 1'b0;
    logic                 rst, clear, in_valid;
    logic [NC*DW-1:0]     current_in, threshold;
    logic                 out_valid;
    logic [NC-1:0]        out_spike;
    logic [NC*TW-1:0]     accumulated_spikes;
    logic [NC*DW-1:0]     membrane_out;

    activation_unit_n #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .TIMER_WIDTH(TW), .LEAK_SHIFT(LS)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .current_in(current_in), .threshold(threshold),
        .out_valid(out_valid), .out_spike(out_spike),
        .accumulated_spikes(accumulated_spikes), .membrane_out(membrane_out)
    );

    always #5 clk = ~clk;

    typedef logic [NC-1:0][DW-1:0] dvec_t;
    typedef logic [NC-1:0][TW-1:0] cvec_t;

    typedef struct packed {
        logic          v;
        logic          c;
        dvec_t         cur;
        dvec_t         thr;
        logic          ev;
        logic [NC-1:0] es;
        dvec_t         em;
        cvec_t         ec;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int            mv[NC];
    int            mc[NC];
    logic          m_ev;
    logic [NC-1:0] m_es;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) begin
            mv[i] = 0;
            mc[i] = 0;
        end
        m_ev = 1'b0;
        m_es = '0;
    endfunction

    function automatic void model_step(input logic v, input logic c, input dvec_t cur, input dvec_t thr);
        int s, t, b;
        m_ev = v && !c;
        m_es = '0;
        for (int i = 0; i < NC; i++) begin
            if (c) begin
                mv[i] = 0;
                mc[i] = 0;
            end else if (v) begin
                b = mv[i];
`ifdef ACT_LEAK_EN
                b = b - (b >>> LS);
`endif
                s = b + int'($signed(cur[i]));
                t = int'($signed(thr[i]));
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
                if (t > 0 && s >= t) begin
                    m_es[i] = 1'b1;
                    s = s - t;
                    if (mc[i] < (1 << TW) - 1) mc[i] = mc[i] + 1;
                end
                mv[i] = s;
            end
        end
    endfunction

    function automatic logic [63:0] model_mem();
        logic [63:0] r = '0;
        for (int i = 0; i < NC; i++) r[i*DW +: DW] = mv[i][DW-1:0];
        return r;
    endfunction

    function automatic logic [63:0] model_cnt();
        logic [63:0] r = '0;
        for (int i = 0; i < NC; i++) r[i*TW +: TW] = mc[i][TW-1:0];
        return r;
    endfunction

    task automatic apply(input logic v, input logic c, input dvec_t cur, input dvec_t thr);
        in_valid   = v;
        clear      = c;
        current_in = cur;
        threshold  = thr;
        @(posedge clk);
        #1;
        model_step(v, c, cur, thr);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'(m_ev));
        check({tag, ".spike"}, 64'(out_spike), 64'(m_es));
        check({tag, ".mem"},   64'(membrane_out), model_mem());
        check({tag, ".cnt"},   64'(accumulated_spikes), model_cnt());
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'd0);
        check({tag, ".spike"}, 64'(out_spike), 64'd0);
        check({tag, ".mem"},   64'(membrane_out), 64'd0);
        check({tag, ".cnt"},   64'(accumulated_spikes), 64'd0);
    endtask

    vec_t  tbl[7];
    dvec_t cur_r, thr_r;

    initial begin
        dvec_t c0, t0, cz;
        c0 = {-16'sd10, 16'sd1000, 16'sd28672, 16'sd40};
        t0 = {16'sd50, 16'sd0, 16'sd32767, 16'sd100};
        cz = {16'h8000, 16'sd0, 16'sd0, 16'sd0};
        tbl[0] = '{1'b1, 1'b0, c0, t0, 1'b1, 4'b0000,
                   {-16'sd10, 16'sd1000, 16'sd28672, 16'sd40}, {5'd0, 5'd0, 5'd0, 5'd0}};
        tbl[1] = '{1'b1, 1'b0, c0, t0, 1'b1, 4'b0010,
                   {-16'sd20, 16'sd2000, 16'sd0, 16'sd80}, {5'd0, 5'd0, 5'd1, 5'd0}};
        tbl[2] = '{1'b1, 1'b0, c0, t0, 1'b1, 4'b0001,
                   {-16'sd30, 16'sd3000, 16'sd28672, 16'sd20}, {5'd0, 5'd0, 5'd1, 5'd1}};
        tbl[3] = '{1'b0, 1'b0, c0, t0, 1'b0, 4'b0000,
                   {-16'sd30, 16'sd3000, 16'sd28672, 16'sd20}, {5'd0, 5'd0, 5'd1, 5'd1}};
        tbl[4] = '{1'b1, 1'b1, c0, t0, 1'b0, 4'b0000,
                   {16'sd0, 16'sd0, 16'sd0, 16'sd0}, {5'd0, 5'd0, 5'd0, 5'd0}};
        tbl[5] = '{1'b1, 1'b0, c0, t0, 1'b1, 4'b0000,
                   {-16'sd10, 16'sd1000, 16'sd28672, 16'sd40}, {5'd0, 5'd0, 5'd0, 5'd0}};
        tbl[6] = '{1'b1, 1'b0, cz, t0, 1'b1, 4'b0000,
                   {16'h8000, 16'sd1000, 16'sd28672, 16'sd40}, {5'd0, 5'd0, 5'd0, 5'd0}};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; current_in = '0; threshold = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // directed table
        for (int k = 0; k < 7; k++) begin
            apply(tbl[k].v, tbl[k].c, tbl[k].cur, tbl[k].thr);
            check($sformatf("tbl%0d.valid", k), 64'(out_valid), 64'(tbl[k].ev));
            check($sformatf("tbl%0d.spike", k), 64'(out_spike), 64'(tbl[k].es));
            check($sformatf("tbl%0d.mem", k),   64'(membrane_out), 64'(tbl[k].em));
            check($sformatf("tbl%0d.cnt", k),   64'(accumulated_spikes), 64'(tbl[k].ec));
        end

        // spike counter saturates at 31
        apply(1'b0, 1'b1, '0, '0);
        cur_r = {16'sd0, 16'sd0, 16'sd0, 16'sd1};
        thr_r = {16'sd0, 16'sd0, 16'sd0, 16'sd1};
        for (int k = 1; k <= 40; k++) begin
            apply(1'b1, 1'b0, cur_r, thr_r);
            check($sformatf("sat%0d.spike0", k), 64'(out_spike[0]), 64'd1);
            check($sformatf("sat%0d.cnt0", k), 64'(accumulated_spikes[TW-1:0]), 64'((k < 31) ? k : 31));
        end

        // asynchronous reset between edges
        cur_r = {16'sd7, 16'sd300, -16'sd55, 16'sd90};
        thr_r = {16'sd5, 16'sd0, 16'sd1000, 16'sd1000};
        repeat (3) apply(1'b1, 1'b0, cur_r, thr_r);
        check_model("pre_rst");
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_zero("async_rst");
        #1 rst = 1'b0;
        cur_r = {16'sd0, 16'sd0, 16'sd0, 16'sd123};
        apply(1'b1, 1'b0, cur_r, thr_r);
        check("post_rst.mem0", 64'(membrane_out[DW-1:0]), 64'd123);
        check_model("post_rst");

`ifdef ACT_LEAK_EN
        apply(1'b0, 1'b1, '0, '0);
        thr_r = {16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000};
        apply(1'b1, 1'b0, {16'sd0, 16'sd0, 16'sd0, 16'sd64}, thr_r);
        check("leak.start", 64'(membrane_out[DW-1:0]), 64'd64);
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b0, '0, thr_r);
            check($sformatf("leak%0d", k), 64'(membrane_out[DW-1:0]), 64'(32 >> k));
        end
`endif

        // randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NC; i++) begin
                case ($urandom_range(0, 3))
                    0: cur_r[i] = DW'($urandom);
                    default: cur_r[i] = DW'(int'($urandom_range(0, 400)) - 150);
                endcase
                case ($urandom_range(0, 4))
                    0: thr_r[i] = DW'(int'($urandom_range(0, 20)) - 10);
                    1: thr_r[i] = DW'($urandom);
                    default: thr_r[i] = DW'($urandom_range(1, 600));
                endcase
            end
            apply(($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0), cur_r, thr_r);
            check_model($sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
